// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared Gen1/Gen2 PHY constants and the 8-bit scrambler LFSR advance.
package pcie_phy_pkg;
   localparam logic [15:0] SEED        = 16'hFFFF;
   localparam logic [7:0]  COM_SYM     = 8'hBC;
   localparam logic [7:0]  SKP_SYM     = 8'h1C;
   localparam logic [3:0]  OS_DATA_LEN = 4'd15;
   localparam logic [15:0] SCR_POLY    = 16'h0039;
   // Returns {keystream byte, lfsr after 8 shifts}; bit0 of the byte is the first stage-15 output.
   function automatic logic [23:0] lfsr_adv8(input logic [15:0] s);
      logic [15:0] l;
      logic [7:0]  ks;
      l  = s;
      ks = '0;
      for (int i = 0; i < 8; i++) begin
         ks[i] = l[15];
         l     = {l[14:0], 1'b0} ^ (l[15] ? SCR_POLY : 16'h0000);
      end
      return {ks, l};
   endfunction
endpackage

// File: rtl/descrambler_byte_step.sv
// descrambler_byte_step: one symbol of descrambling, including COM reseed, SKP hold and
// ordered-set data bypass.
module descrambler_byte_step
   import pcie_phy_pkg::*;
(
   input  logic [15:0] lfsr,
   input  logic [3:0]  os_cnt,
   input  logic [7:0]  sym,
   input  logic        k,
   input  logic        en,
   output logic [7:0]  sym_out,
   output logic [15:0] lfsr_next,
   output logic [3:0]  os_cnt_next
);
   logic        w_com;
   logic        w_skp;
   logic [23:0] w_adv;
   assign w_com       = k && sym == COM_SYM;
   assign w_skp       = k && sym == SKP_SYM;
   assign w_adv       = lfsr_adv8(lfsr);
   assign lfsr_next   = w_com ? SEED : w_skp ? lfsr : w_adv[15:0];
   assign os_cnt_next = w_com ? OS_DATA_LEN : (w_skp || os_cnt == 4'd0) ? os_cnt : os_cnt - 4'd1;
   assign sym_out     = (en && !k && os_cnt == 4'd0) ? sym ^ w_adv[23:16] : sym;
endmodule

// File: rtl/rx_descrambler_32.sv
// rx_descrambler_32: 4-symbol-per-clock Gen1/Gen2 receive descrambler with registered outputs.
module rx_descrambler_32
   import pcie_phy_pkg::*;
(
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        descramble_en,
   input  logic [31:0] rx_data_in,
   input  logic [3:0]  rx_datak_in,
   input  logic        rx_valid_in,
   output logic [31:0] rx_data_out,
   output logic [3:0]  rx_datak_out,
   output logic        rx_valid_out
);
   logic [15:0] r_lfsr;
   logic [3:0]  r_os_cnt;
   logic [31:0] r_data_out;
   logic [3:0]  r_datak_out;
   logic        r_valid_out;
   logic [15:0] w_lfsr [0:4];
   logic [3:0]  w_os   [0:4];
   logic [31:0] w_data;
   assign w_lfsr[0] = r_lfsr;
   assign w_os[0]   = r_os_cnt;
   // Byte 0 is first in time, so state ripples upward through the word.
   for (genvar g = 0; g < 4; g++) begin : gen_byte
      descrambler_byte_step u_step (
         .lfsr        (w_lfsr[g]),
         .os_cnt      (w_os[g]),
         .sym         (rx_data_in[8*g +: 8]),
         .k           (rx_datak_in[g]),
         .en          (descramble_en),
         .sym_out     (w_data[8*g +: 8]),
         .lfsr_next   (w_lfsr[g+1]),
         .os_cnt_next (w_os[g+1])
      );
   end
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr      <= SEED;
         r_os_cnt    <= '0;
         r_data_out  <= '0;
         r_datak_out <= '0;
         r_valid_out <= 1'b0;
      end else begin
         r_valid_out <= rx_valid_in;
         if (rx_valid_in) begin
            r_lfsr      <= w_lfsr[4];
            r_os_cnt    <= w_os[4];
            r_data_out  <= w_data;
            r_datak_out <= rx_datak_in;
         end
      end
   end
   assign rx_data_out  = r_data_out;
   assign rx_datak_out = r_datak_out;
   assign rx_valid_out = r_valid_out;
endmodule

// File: tb/tb_rx_descrambler_32.sv
// tb_rx_descrambler_32: directed stimulus with a queued scoreboard and an independent
// serial keystream reference.
module tb_rx_descrambler_32;
   logic        pclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        descramble_en = 1'b1;
   logic [31:0] rx_data_in = '0;
   logic [3:0]  rx_datak_in = '0;
   logic        rx_valid_in = 1'b0;
   logic [31:0] rx_data_out;
   logic [3:0]  rx_datak_out;
   logic        rx_valid_out;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic [3:0]  k;
      string       name;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   logic [7:0]  ks [0:63];
   logic [31:0] last_d = '0;
   logic [3:0]  last_k = '0;
   int          errors = 0;
   int          checks = 0;

   always #5 pclk = ~pclk;

   rx_descrambler_32 dut (
      .pclk          (pclk),
      .reset_n       (reset_n),
      .descramble_en (descramble_en),
      .rx_data_in    (rx_data_in),
      .rx_datak_in   (rx_datak_in),
      .rx_valid_in   (rx_valid_in),
      .rx_data_out   (rx_data_out),
      .rx_datak_out  (rx_datak_out),
      .rx_valid_out  (rx_valid_out)
   );

   function automatic logic [31:0] kw(input int n);
      return {ks[n+3], ks[n+2], ks[n+1], ks[n]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic [31:0] e, input string name, input logic en = 1'b1);
      @(negedge pclk);
      rx_valid_in   = v;
      rx_data_in    = d;
      rx_datak_in   = k;
      descramble_en = en;
      if (v) begin
         last_d = e;
         last_k = k;
      end
      q.push_back('{v, last_d, last_k, name});
   endtask

   always @(posedge pclk) begin
      #1;
      if (q.size() != 0) begin
         me = q.pop_front();
         chk({me.name, " valid"}, {31'b0, rx_valid_out}, {31'b0, me.v});
         chk({me.name, " data"}, rx_data_out, me.d);
         chk({me.name, " datak"}, {28'b0, rx_datak_out}, {28'b0, me.k});
      end
   end

   initial begin
      logic [15:0] s;
      logic        fb;
      s = 16'hFFFF;
      for (int n = 0; n < 64; n++)
         for (int i = 0; i < 8; i++) begin
            fb       = s[15];
            ks[n][i] = fb;
            s        = {s[14:5], s[4] ^ fb, s[3] ^ fb, s[2] ^ fb, s[1], s[0], fb};
         end
      repeat (3) @(negedge pclk);
      chk("reset data", rx_data_out, 32'h0);
      chk("reset datak", {28'b0, rx_datak_out}, 32'h0);
      chk("reset valid", {31'b0, rx_valid_out}, 32'h0);
      reset_n = 1'b1;
      send(1, 32'h0, 4'b0000, 32'h14C017FF, "seed_w0");
      send(1, 32'h0, 4'b0000, 32'h8202E7B2, "seed_w1");
      send(1, 32'h00001C00, 4'b0010, {ks[10], ks[9], 8'h1C, ks[8]}, "skp_b1");
      repeat (3) send(0, 32'hFFFFFFFF, 4'b1111, 32'h0, "idle");
      send(1, 32'hFFFFFFFF, 4'b0000, ~kw(11), "after_idle");
      send(1, 32'hA55A3CBC, 4'b0001, 32'hA55A3CBC, "com_b0");
      send(1, 32'h11223344, 4'b0000, 32'h11223344, "ts_body1");
      send(1, 32'h55667788, 4'b0000, 32'h55667788, "ts_body2");
      send(1, 32'h99AABBCC, 4'b0000, 32'h99AABBCC, "ts_body3");
      send(1, 32'h0, 4'b0000, kw(15), "ks_off15");
      send(1, 32'hDEADBEEF, 4'b0000, 32'hDEADBEEF, "bypass", 1'b0);
      send(1, 32'h0, 4'b0000, kw(23), "reenable");
      send(1, 32'h0000007C, 4'b0001, {ks[30], ks[29], ks[28], 8'h7C}, "k_other");
      send(1, 32'h00BC0000, 4'b0100, {8'h00, 8'hBC, ks[32], ks[31]}, "com_b2");
      send(0, 32'h0, 4'b0000, 32'h0, "drain");
      @(negedge pclk);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset data", rx_data_out, 32'h0);
      chk("async reset datak", {28'b0, rx_datak_out}, 32'h0);
      @(negedge pclk);
      reset_n = 1'b1;
      last_d  = '0;
      last_k  = '0;
      send(1, 32'h0, 4'b0000, 32'h14C017FF, "post_reset");
      send(1, 32'h0, 4'b0000, 32'h8202E7B2, "post_reset2");
      send(0, 32'h0, 4'b0000, 32'h0, "final_idle");
      for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge pclk);
      if (q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
